// File: rtl/scan_job_scheduler.sv
// scan_job_scheduler: round-robin sharing of one scan pattern generator among NUM_REQ requesters.
// Performance counters are built only when SCAN_SCHED_PERF_EN is defined.
module scan_job_scheduler #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [3*NUM_REQ-1:0] req_log2w,
   input  logic [3*NUM_REQ-1:0] req_log2h,
   input  logic [2*NUM_REQ-1:0] req_scan_type,
   output logic                 gen_start,
   output logic [2:0]           gen_log2w,
   output logic [2:0]           gen_log2h,
   output logic [1:0]           gen_scan_type,
   input  logic                 gen_scan_valid,
   input  logic [9:0]           gen_scan_position,
   input  logic                 gen_done,
   output logic                 out_valid,
   output logic [9:0]           out_pos,
   output logic [ID_W-1:0]      out_id,
   output logic                 cpl_valid,
   output logic [ID_W-1:0]      cpl_id,
   output logic                 cpl_err,
   output logic                 busy,
   output logic [15:0]          perf_jobs,
   output logic [31:0]          perf_busy_cycles
);
   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, ERR} state_t;
   state_t state, state_nx;
   logic [ID_W-1:0] rr_ptr, grant, idx, id;
   logic found, accept, illegal, finish;
   logic [2:0] sel_w, sel_h;
   logic [1:0] sel_t;
   // Highest offset is scanned first so the nearest valid requester after rr_ptr wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (req_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end
   // A stuck gen_done in IDLE blocks granting until the generator is idle again.
   assign accept    = (state == IDLE) && found && !gen_done;
   assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
   assign sel_w     = req_log2w[3*int'(grant) +: 3];
   assign sel_h     = req_log2h[3*int'(grant) +: 3];
   assign sel_t     = req_scan_type[2*int'(grant) +: 2];
   assign illegal   = sel_w > 3'd5 || sel_h > 3'd5 || sel_t == 2'd3;
   assign finish    = (state == ISSUE && gen_done) || state == ERR;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? (illegal ? ERR : ISSUE) : IDLE;
         ISSUE:   state_nx = gen_done ? RELEASE : ISSUE;
         RELEASE: state_nx = gen_done ? RELEASE : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         id            <= '0;
         gen_log2w     <= '0;
         gen_log2h     <= '0;
         gen_scan_type <= '0;
         cpl_valid     <= 1'b0;
         cpl_id        <= '0;
         cpl_err       <= 1'b0;
      end else begin
         state     <= state_nx;
         cpl_valid <= finish;
         if (accept) begin
            id            <= grant;
            gen_log2w     <= sel_w;
            gen_log2h     <= sel_h;
            gen_scan_type <= sel_t;
            rr_ptr        <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
         end
         if (finish) begin
            cpl_id  <= id;
            cpl_err <= state == ERR;
         end
      end
   end
   assign gen_start = state == ISSUE;
   assign busy      = state != IDLE;
   assign out_valid = gen_scan_valid && state == ISSUE;
   assign out_pos   = gen_scan_position;
   assign out_id    = id;
`ifdef SCAN_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_jobs        <= '0;
         perf_busy_cycles <= '0;
      end else begin
         if (cpl_valid && !cpl_err && perf_jobs != 16'hFFFF)
            perf_jobs <= perf_jobs + 1'b1;
         if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
            perf_busy_cycles <= perf_busy_cycles + 1'b1;
      end
   end
`else
   assign perf_jobs        = '0;
   assign perf_busy_cycles = '0;
`endif
endmodule
